// File: rtl/systolic_feeder.sv
// Transmit-side sequencer for a 2x2 weight-stationary systolic array: column size strobe,
// skewed weight load, bank switch, skewed input streaming and drain with completion pulse.
module systolic_feeder #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int DATA_WIDTH           = 16,
  parameter int DRAIN_CYCLES         = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_start,
  input  logic [DATA_WIDTH-1:0] cmd_rows,
  input  logic [DATA_WIDTH-1:0] cmd_cols,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] w_data_1,
  input  logic [DATA_WIDTH-1:0] w_data_2,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_data_1,
  input  logic [DATA_WIDTH-1:0] x_data_2,
  output logic [DATA_WIDTH-1:0] ub_rd_col_size_in,
  output logic                  ub_rd_col_size_valid_in,
  output logic [DATA_WIDTH-1:0] sys_weight_in_x1,
  output logic [DATA_WIDTH-1:0] sys_weight_in_x2,
  output logic                  sys_accept_w_1,
  output logic                  sys_accept_w_2,
  output logic                  sys_switch_in,
  output logic [DATA_WIDTH-1:0] sys_data_in_1x,
  output logic [DATA_WIDTH-1:0] sys_data_in_2x,
  output logic                  sys_start,
  output logic                  busy,
  output logic                  done
);

  // state  | meaning
  // IDLE   | waiting for cmd_start
  // CFG    | column size strobe to the array
  // LOAD_W | accepting weight rows, then letting the column-2 skew flush
  // SWITCH | one-cycle weight bank switch
  // STREAM | accepting input rows until rows_left reaches 0
  // DRAIN  | waiting for the array to empty; done on the last cycle
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG    = 3'd1,
    LOAD_W = 3'd2,
    SWITCH = 3'd3,
    STREAM = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  localparam int WCW = $clog2(SYSTOLIC_ARRAY_WIDTH + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WCW-1:0]        W_BEATS  = WCW'(SYSTOLIC_ARRAY_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MAX_COLS = DATA_WIDTH'(SYSTOLIC_ARRAY_WIDTH);

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] rows_left;
  logic [WCW-1:0]        w_cnt;
  logic [DATA_WIDTH-1:0] w2_skew, x2_skew;
  logic                  w2_skew_vld, x2_skew_vld, x2_out_vld;
  logic [DCW-1:0]        drain_cnt;
  logic                  w_beat, x_beat, drain_run;

  assign w_ready   = (state == LOAD_W) && (w_cnt != W_BEATS);
  assign x_ready   = (state == STREAM) && (rows_left != '0);
  assign busy      = (state != IDLE);
  assign w_beat    = w_valid && w_ready;
  assign x_beat    = x_valid && x_ready;
  // drain time only counts once the last skewed column-2 element has left
  assign drain_run = !x2_skew_vld && !x2_out_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_start) next_state = CFG;
      CFG:     next_state = LOAD_W;
      LOAD_W:  if ((w_cnt == W_BEATS) && !w2_skew_vld) next_state = SWITCH;
      SWITCH:  next_state = (rows_left != '0) ? STREAM : DRAIN;
      STREAM:  if (x_beat && (rows_left == DATA_WIDTH'(1))) next_state = DRAIN;
      DRAIN:   if (drain_run && (drain_cnt == DCW'(1))) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_left               <= '0;
      w_cnt                   <= '0;
      ub_rd_col_size_in       <= '0;
      ub_rd_col_size_valid_in <= 1'b0;
      sys_weight_in_x1        <= '0;
      sys_weight_in_x2        <= '0;
      sys_accept_w_1          <= 1'b0;
      sys_accept_w_2          <= 1'b0;
      w2_skew                 <= '0;
      w2_skew_vld             <= 1'b0;
      sys_switch_in           <= 1'b0;
      sys_data_in_1x          <= '0;
      sys_data_in_2x          <= '0;
      sys_start               <= 1'b0;
      x2_skew                 <= '0;
      x2_skew_vld             <= 1'b0;
      x2_out_vld              <= 1'b0;
      drain_cnt               <= '0;
      done                    <= 1'b0;
    end else begin
      ub_rd_col_size_valid_in <= 1'b0;
      if ((state == IDLE) && cmd_start) begin
        rows_left               <= cmd_rows;
        ub_rd_col_size_in       <= (cmd_cols > MAX_COLS) ? MAX_COLS : cmd_cols;
        ub_rd_col_size_valid_in <= 1'b1;
      end else if (x_beat) begin
        rows_left <= rows_left - DATA_WIDTH'(1);
      end

      if (state == CFG)  w_cnt <= '0;
      else if (w_beat)   w_cnt <= w_cnt + WCW'(1);

      // column 2 sees each weight one cycle after column 1
      sys_accept_w_1   <= w_beat;
      sys_weight_in_x1 <= w_beat ? w_data_1 : '0;
      w2_skew_vld      <= w_beat;
      w2_skew          <= w_beat ? w_data_2 : '0;
      sys_accept_w_2   <= w2_skew_vld;
      sys_weight_in_x2 <= w2_skew;

      sys_switch_in <= (state == LOAD_W) && (next_state == SWITCH);

      sys_start      <= x_beat;
      sys_data_in_1x <= x_beat ? x_data_1 : '0;
      x2_skew_vld    <= x_beat;
      x2_skew        <= x_beat ? x_data_2 : '0;
      x2_out_vld     <= x2_skew_vld;
      sys_data_in_2x <= x2_skew;

      if ((state != DRAIN) && (next_state == DRAIN))
        drain_cnt <= DCW'(DRAIN_CYCLES);
      else if ((state == DRAIN) && drain_run && (drain_cnt != '0))
        drain_cnt <= drain_cnt - DCW'(1);

      // registered done lands on the final drain cycle (count 1)
      done <= (state == DRAIN) && drain_run && (drain_cnt == DCW'(2));
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: directed commands with random data and valid
// patterns, checked against an event-timing model derived from the accepted handshakes.
module tb_systolic_feeder;

  typedef struct { int cyc; int val; } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [15:0] cmd_rows, cmd_cols;
  logic        w_valid, w_ready, x_valid, x_ready;
  logic [15:0] w_data_1, w_data_2, x_data_1, x_data_2;
  logic [15:0] ub_rd_col_size_in;
  logic        ub_rd_col_size_valid_in;
  logic [15:0] sys_weight_in_x1, sys_weight_in_x2;
  logic        sys_accept_w_1, sys_accept_w_2, sys_switch_in;
  logic [15:0] sys_data_in_1x, sys_data_in_2x;
  logic        sys_start, busy, done;
  logic [89:0] all_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int stale_cnt = 0;
  int done_cnt  = 0;
  ev_t obs_ub[$], obs_a1[$], obs_a2[$], obs_sw[$], obs_st[$], obs_x2[$];
  int b_ub, b_a1, b_a2, b_sw, b_st, b_x2;

  systolic_feeder dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_rows(cmd_rows), .cmd_cols(cmd_cols),
    .w_valid(w_valid), .w_ready(w_ready), .w_data_1(w_data_1), .w_data_2(w_data_2),
    .x_valid(x_valid), .x_ready(x_ready), .x_data_1(x_data_1), .x_data_2(x_data_2),
    .ub_rd_col_size_in(ub_rd_col_size_in), .ub_rd_col_size_valid_in(ub_rd_col_size_valid_in),
    .sys_weight_in_x1(sys_weight_in_x1), .sys_weight_in_x2(sys_weight_in_x2),
    .sys_accept_w_1(sys_accept_w_1), .sys_accept_w_2(sys_accept_w_2),
    .sys_switch_in(sys_switch_in), .sys_data_in_1x(sys_data_in_1x),
    .sys_data_in_2x(sys_data_in_2x), .sys_start(sys_start), .busy(busy), .done(done)
  );

  assign all_out = {ub_rd_col_size_in, ub_rd_col_size_valid_in, sys_weight_in_x1,
                    sys_weight_in_x2, sys_accept_w_1, sys_accept_w_2, sys_switch_in,
                    sys_data_in_1x, sys_data_in_2x, sys_start, busy, done, w_ready, x_ready};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ub_rd_col_size_valid_in) obs_ub.push_back('{cyc, int'(ub_rd_col_size_in)});
    if (sys_accept_w_1) obs_a1.push_back('{cyc, int'(sys_weight_in_x1)});
    if (sys_accept_w_2) obs_a2.push_back('{cyc, int'(sys_weight_in_x2)});
    if (sys_switch_in)  obs_sw.push_back('{cyc, 1});
    if (sys_start)      obs_st.push_back('{cyc, int'(sys_data_in_1x)});
    if (sys_data_in_2x != 16'd0) obs_x2.push_back('{cyc, int'(sys_data_in_2x)});
    if ((!sys_accept_w_1 && sys_weight_in_x1 != 16'd0) ||
        (!sys_accept_w_2 && sys_weight_in_x2 != 16'd0) ||
        (!sys_start && sys_data_in_1x != 16'd0))
      stale_cnt <= stale_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    n_tests++;
    assert (all_out === 90'd0) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected all zero", tag, all_out);
    end
  endtask

  task automatic sync_bases();
    b_ub = obs_ub.size(); b_a1 = obs_a1.size(); b_a2 = obs_a2.size();
    b_sw = obs_sw.size(); b_st = obs_st.size(); b_x2 = obs_x2.size();
  endtask

  task automatic cmp_events(input string tag, input ev_t exp_q[$], input ev_t obs_q[$],
                            input int base);
    chk({tag, "_count"}, obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && (base + i) < obs_q.size(); i++) begin
      chk({tag, "_cycle"}, obs_q[base + i].cyc, exp_q[i].cyc);
      chk({tag, "_value"}, obs_q[base + i].val, exp_q[i].val);
    end
  endtask

  function automatic bit want(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return $urandom_range(0, 1) == 1;
    endcase
  endfunction

  function automatic logic [15:0] rnd16();
    return 16'($urandom_range(1, 65535));
  endfunction

  // Expected timing: beat at cycle c -> column 1 at c+1, column 2 at c+2; switch 3 cycles
  // after the last weight beat; done 5 cycles after the last column-2 input (or after switch).
  task automatic run_cmd(input int rows, input int cols, input int wmode, input int xmode,
                         input bit fixed, input bit poke, input int abort_after);
    ev_t e_ub[$], e_a1[$], e_a2[$], e_sw[$], e_st[$], e_x2[$];
    int  wb = 0, xb = 0, last_w = 0, last_x = 0, done_cyc = -1, exp_done, limit, dc0;
    int  exp_cols;
    bit  poked = 0, busy_at_done = 0;
    exp_cols  = (cols > 2) ? 2 : cols;
    cmd_rows  = 16'(rows);
    cmd_cols  = 16'(cols);
    cmd_start = 1'b1;
    e_ub.push_back('{cyc + 1, exp_cols});
    @(negedge clk);
    cmd_start = 1'b0;
    limit = (wmode == 0 && xmode == 0) ? rows + 60 : 6 * rows + 120;
    for (int n = 0; n < limit && done_cyc < 0; n++) begin
      w_valid  = (wb < 2) && want(wmode);
      w_data_1 = fixed ? 16'(2 * wb + 1) : rnd16();
      w_data_2 = fixed ? 16'(2 * wb + 2) : rnd16();
      x_valid  = (xb < rows) && want(xmode);
      x_data_1 = fixed ? 16'(2 * xb + 5) : rnd16();
      x_data_2 = fixed ? 16'(2 * xb + 6) : rnd16();
      cmd_start = poke && x_ready && !poked;
      if (cmd_start) poked = 1'b1;
      if (w_valid && w_ready) begin
        e_a1.push_back('{cyc + 1, int'(w_data_1)});
        e_a2.push_back('{cyc + 2, int'(w_data_2)});
        wb++;
        last_w = cyc;
        if (wb == 2) e_sw.push_back('{cyc + 3, 1});
      end
      if (x_valid && x_ready) begin
        e_st.push_back('{cyc + 1, int'(x_data_1)});
        e_x2.push_back('{cyc + 2, int'(x_data_2)});
        xb++;
        last_x = cyc;
        if (abort_after > 0 && xb == abort_after) begin
          dc0 = done_cnt;
          @(posedge clk);
          #2 rst = 1'b1;
          #1 chk_all_zero("abort_outputs_zero");
          w_valid = 1'b0; x_valid = 1'b0; cmd_start = 1'b0;
          repeat (3) @(negedge clk);
          rst = 1'b0;
          repeat (8) @(negedge clk);
          chk("abort_no_done", done_cnt, dc0);
          chk("abort_busy_idle", busy, 0);
          sync_bases();
          return;
        end
      end
      if (done) begin
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      @(negedge clk);
    end
    w_valid = 1'b0; x_valid = 1'b0; cmd_start = 1'b0;
    exp_done = (rows > 0) ? last_x + 7 : last_w + 8;
    chk("done_seen", int'(done_cyc >= 0), 1);
    if (done_cyc >= 0) begin
      chk("done_cycle", done_cyc, exp_done);
      chk("busy_at_done", busy_at_done, 1);
      chk("busy_after_done", busy, 0);
    end
    chk("ub_size_hold", ub_rd_col_size_in, exp_cols);
    chk("stale_outputs", stale_cnt, 0);
    cmp_events("ub_strobe", e_ub, obs_ub, b_ub);
    cmp_events("accept_w_1", e_a1, obs_a1, b_a1);
    cmp_events("accept_w_2", e_a2, obs_a2, b_a2);
    cmp_events("switch", e_sw, obs_sw, b_sw);
    cmp_events("start_1x", e_st, obs_st, b_st);
    cmp_events("data_2x", e_x2, obs_x2, b_x2);
    sync_bases();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cmd_start = 1'b0; cmd_rows = '0; cmd_cols = '0;
    w_valid = 1'b0; w_data_1 = '0; w_data_2 = '0;
    x_valid = 1'b0; x_data_1 = '0; x_data_2 = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("idle_outputs");
    sync_bases();

    run_cmd(3, 2, 0, 0, 1'b1, 1'b0, 0);     // fixed weights (1,2),(3,4), inputs 5..10
    run_cmd(4, 2, 1, 1, 1'b0, 1'b0, 0);     // valids toggling every other cycle
    run_cmd(0, 1, 0, 0, 1'b0, 1'b0, 0);     // no input rows
    run_cmd(3, 2, 0, 2, 1'b0, 1'b1, 0);     // stray cmd_start during STREAM
    run_cmd(2, 7, 2, 2, 1'b0, 1'b0, 0);     // column count clamps to 2
    run_cmd(6, 0, 2, 2, 1'b0, 1'b0, 0);     // zero columns still sequences
    run_cmd(5, 2, 0, 0, 1'b0, 1'b0, 2);     // reset after the 2nd input beat
    run_cmd(4, 1, 2, 2, 1'b0, 1'b0, 0);     // normal command after abort
    run_cmd(65535, 2, 0, 0, 1'b0, 1'b0, 0); // maximum row count

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit-side sequencer driving a 2x2 weight-stationary systolic array from unified-buffer streams.
- Per command:
  - programs the active column count;
  - shifts two weight rows into the array with one-cycle column skew, then pulses the weight switch;
  - streams N input rows with one-cycle column skew and a valid marker;
  - drains the array and reports completion.
- Sits between the unified-buffer read ports and the array's input, weight and control pins.

Parameters:
- SYSTOLIC_ARRAY_WIDTH, 2, array rows/columns; number of weight rows loaded per command.
- DATA_WIDTH, 16, width of every data, weight and size word.
- DRAIN_CYCLES, 5, idle cycles after the last input row before done (2*width+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cmd_start  in  1  one-cycle command pulse; sampled only in IDLE
- cmd_rows  in  16  input rows to stream; 0 is legal
- cmd_cols  in  16  active column count; clamped to SYSTOLIC_ARRAY_WIDTH
- w_valid  in  1  weight row valid
- w_ready  out  1  weight row accepted when w_valid & w_ready
- w_data_1  in  16  weight, column 1
- w_data_2  in  16  weight, column 2
- x_valid  in  1  input row valid
- x_ready  out  1  input row accepted when x_valid & x_ready
- x_data_1  in  16  input element for row port 1x
- x_data_2  in  16  input element for row port 2x
- ub_rd_col_size_in  out  16  column count to the array
- ub_rd_col_size_valid_in  out  1  one-cycle strobe qualifying ub_rd_col_size_in
- sys_weight_in_x1  out  16  weight into column 1
- sys_weight_in_x2  out  16  weight into column 2
- sys_accept_w_1  out  1  column-1 weight shift enable
- sys_accept_w_2  out  1  column-2 weight shift enable
- sys_switch_in  out  1  one-cycle weight bank switch
- sys_data_in_1x  out  16  input data, port 1x
- sys_data_in_2x  out  16  input data, port 2x
- sys_start  out  1  valid marker accompanying sys_data_in_1x
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values:
  - all outputs 0, including ub_rd_col_size_in, w_ready and x_ready;
  - state IDLE, all counters and skew registers 0.
  - Reset mid-operation aborts immediately. No done pulse is issued. Partially loaded weights are abandoned.
- All array-facing outputs are registered. Data and weight outputs are 0 in any cycle with no corresponding accepted beat; they do not hold stale values.
- States: IDLE -> CFG -> LOAD_W -> SWITCH -> STREAM -> DRAIN -> IDLE.
- IDLE:
  - cmd_start latches rows_left = cmd_rows and cols = min(cmd_cols, SYSTOLIC_ARRAY_WIDTH), then moves to CFG.
  - cmd_start outside IDLE is ignored.
- CFG (1 cycle): ub_rd_col_size_valid_in = 1 and ub_rd_col_size_in = cols. ub_rd_col_size_in then holds that value until the next CFG. Next state LOAD_W.
- LOAD_W:
  - w_ready = 1 until SYSTOLIC_ARRAY_WIDTH beats have been accepted; a beat counter runs 0..W-1.
  - Beat accepted at edge t:
    - sys_weight_in_x1 = w_data_1 and sys_accept_w_1 = 1 in cycle t+1;
    - sys_weight_in_x2 = w_data_2 and sys_accept_w_2 = 1 in cycle t+2, via a skew register.
  - Gaps in w_valid produce accept = 0 cycles with a skew that stays consistent.
  - w_ready drops in the cycle after the last beat. Next state SWITCH.
- SWITCH:
  - sys_switch_in = 1 for exactly one cycle, in the cycle immediately after the last sys_accept_w_2 = 1 cycle (t+3 for last beat at t).
  - Next state is STREAM if rows_left > 0, else DRAIN.
- STREAM:
  - x_ready = 1 while rows_left > 0.
  - Beat accepted at edge t:
    - sys_data_in_1x = x_data_1 and sys_start = 1 in cycle t+1;
    - sys_data_in_2x = x_data_2 in cycle t+2.
  - rows_left decrements per beat. After the beat that takes rows_left to 0, x_ready drops and the state moves to DRAIN.
  - Back-to-back beats produce continuous sys_start.
- DRAIN:
  - Counts DRAIN_CYCLES cycles, starting after the final skewed sys_data_in_2x cycle.
  - done = 1 on the last drain cycle, then IDLE. busy falls in the cycle after done.
- Width rules:
  - rows_left is 16-bit; cmd_rows = 65535 is supported.
  - cmd_cols = 0 is passed through as 0, which disables all columns; the sequence still runs.

Test Plan:
- Full run: cmd_start, cmd_cols=2, cmd_rows=3, weights (1,2),(3,4) back-to-back, inputs (5,6),(7,8),(9,10) back-to-back -> required response:
  - ub valid one cycle with 2;
  - accept_w_1 in 2 consecutive cycles carrying 1,3;
  - accept_w_2 one cycle later carrying 2,4;
  - single switch pulse right after;
  - sys_start in 3 consecutive cycles with 1x = 5,7,9 and 2x = 6,8,10 lagging by one cycle;
  - done 5 cycles after the 2x=10 cycle.
- Back-pressure: w_valid and x_valid toggle every other cycle -> accept and sys_start each high for one cycle with one-cycle gaps; outputs are 0 in the gaps; column skew stays exactly one cycle; values are unchanged.
- cmd_rows=0 -> no x_ready, no sys_start; done follows the switch pulse after DRAIN_CYCLES.
- cmd_start pulsed during STREAM and cmd_cols=7 on the next command -> the second start is ignored; the next command drives ub_rd_col_size_in = 2 (clamped).
- Reset asserted after the 2nd input beat -> all outputs 0 within the same cycle; no done; a new command afterwards completes normally.
- cmd_rows=65535 with a continuously valid source -> exactly 65535 sys_start cycles, then done.
